aes128_round_sequencer: RTL and testbench

Iterative AES-128 encryption controller. It reuses one round datapath (SubBytes, ShiftRow, MixColumns, AddRoundKey) and one on-the-fly key-expansion step over 10 cycles, one round per cycle. It sits between the block-input interface and the ciphertext consumer, and uses valid/ready handshakes on both sides. State and key byte order is column-major: bits [127:120] = s[0][0], [119:112] = s[1][0], …, [7:0] = s[3][3]. This is the same mapping the ShiftRow block uses.

---
 rtl/aes128_round_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_aes128_round_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor: one round per cycle,
// on-the-fly key expansion, valid/ready on both sides.
module aes128_round_sequencer #(
  parameter int NR     = 10,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_text,
  input  logic [DATA_W-1:0] in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_text,
  output logic              busy,
  output logic [3:0]        round_idx
);

  if (NR != 10 || DATA_W != 128) begin : g_cfg_err
    $error("aes128_round_sequencer: NR=10, DATA_W=128 only");
  end

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_reg_q, state_reg_d;
  logic [127:0] key_reg_q, key_reg_d;
  logic [3:0]   round_idx_q, round_idx_d;
  logic [127:0] ss, mc, next_key;

  function automatic logic [7:0] xt(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse as x^254 in GF(2^8), then the affine map
  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    logic [7:0] x2, x3, x12, x15, x240, b;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(x3, x3);
    x12  = gmul(x12, x12);
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    b    = gmul(gmul(x240, x12), x2);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
         ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(
    input logic [127:0] s
  );
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = r + 4 * ((c + r) % 4);
        o[127-8*(r+4*c) -: 8] =
          sbox(s[127-8*src -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    logic [7:0] v;
    unique case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [127:0] key_expand(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]),
          sbox(w3[7:0]),   sbox(w3[31:24])};
    t  = t ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_comb begin
    ss       = sub_shift(state_reg_q);
    mc       = mix_cols(ss);
    next_key = key_expand(key_reg_q,
                          rcon(round_idx_q));
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_reg_d = state_reg_q;
    key_reg_d   = key_reg_q;
    round_idx_d = round_idx_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_reg_d = in_text ^ in_key;
          key_reg_d   = in_key;
          round_idx_d = 4'd1;
          fsm_d       = ROUND;
        end
      end
      ROUND: begin
        key_reg_d = next_key;
        if (round_idx_q == 4'(NR)) begin
          state_reg_d = ss ^ next_key;
          fsm_d       = DONE;
        end else begin
          state_reg_d = mc ^ next_key;
          round_idx_d = round_idx_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d       = IDLE;
          round_idx_d = 4'd0;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_reg_q <= '0;
      key_reg_q   <= '0;
      round_idx_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_reg_q <= state_reg_d;
      key_reg_q   <= key_reg_d;
      round_idx_q <= round_idx_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign round_idx = round_idx_q;
  assign out_text  = out_valid ? state_reg_q : '0;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Scoreboarded bench for aes128_round_sequencer
// with a byte-array AES reference model.
module tb_aes128_round_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_text;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;
  logic         busy;
  logic [3:0]   round_idx;

  aes128_round_sequencer #(.NR(10), .DATA_W(128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_text   (in_text),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_text  (out_text),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R0_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int n_acc   = 0;
  logic ov_prev = 1'b0;
  logic rnd_ready = 1'b0;
  logic [127:0] exp_next;
  logic [127:0] exp_q[$];
  logic [7:0] sbox_t [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(
    input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Table built by walking generator 3 and its inverse
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2)
            ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] ref_aes(
    input logic [127:0] pt,
    input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  a [4];
    logic [7:0]  rc;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]],
               sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++)
      s[k] = pt[127-8*k -: 8] ^ key[127-8*k -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox_t[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = s[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = t[r+4*c];
          for (int r = 0; r < 4; r++)
            t[r+4*c] = xtime(a[r]) ^ xtime(a[(r+1)%4])
                       ^ a[(r+1)%4] ^ a[(r+2)%4]
                       ^ a[(r+3)%4];
        end
      end
      for (int k = 0; k < 16; k++)
        s[k] = t[k] ^ w[4*rnd+k/4][31-8*(k%4) -: 8];
    end
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // Acceptance: expected ciphertext enters the scoreboard
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(exp_next);
      acc_cyc = cyc + 1;
      n_acc++;
    end
  end

  // Output monitor: latency, round index, ciphertext order
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && !out_valid)
        chk("round_idx", 128'(round_idx),
            128'(cyc - acc_cyc + 1));
      if (out_valid && !ov_prev)
        chk("latency", 128'(cyc), 128'(acc_cyc + 10));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %h",
                   out_text);
        end else begin
          chk("out_text", out_text, exp_q.pop_front());
        end
      end
    end
    ov_prev = rst_n && out_valid;
  end

  task automatic send(input logic [127:0] t,
                      input logic [127:0] k,
                      input logic [127:0] e,
                      input bit keep);
    int base;
    base = n_acc;
    @(posedge clk);
    #1;
    in_text  = t;
    in_key   = k;
    exp_next = e;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && n_acc == base; i++)
      @(posedge clk);
    if (n_acc == base)
      chk("accept_timeout", 128'(n_acc), 128'(base + 1));
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
    chk("drain", 128'({exp_q.size() != 0, busy}), 128'(0));
    out_ready = 1'b1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] t, k, e;
    int base, first;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_text   = '0;
    in_key    = '0;
    out_ready = 1'b1;
    exp_next  = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_text", out_text, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_round_idx", 128'(round_idx), 128'(0));
    rst_n = 1'b1;

    send(PT_B, K_B, CT_B, 1'b0);
    chk("round0_state", dut.state_reg_q, R0_B);
    drain();

    send(PT_C, K_C, CT_C, 1'b0);
    drain();

    t = rnd128();
    k = rnd128();
    e = ref_aes(t, k);
    out_ready = 1'b0;
    send(t, k, e, 1'b0);
    for (int i = 0; i < 30 && !out_valid; i++)
      @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_out_text", out_text, e);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", 128'(in_ready), 128'(1));
    chk("bp_idle_out_valid", 128'(out_valid), 128'(0));
    drain();

    send(PT_B, K_B, CT_B, 1'b1);
    first    = acc_cyc;
    base     = n_acc;
    in_text  = PT_C;
    in_key   = K_C;
    exp_next = CT_C;
    for (int i = 0; i < 40 && n_acc == base; i++)
      @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_spacing", 128'(acc_cyc - first), 128'(12));
    drain();

    send(PT_B, K_B, CT_B, 1'b0);
    for (int i = 0; i < 20 && round_idx != 4'd5; i++)
      @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_out_text", out_text, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send(PT_B, K_B, CT_B, 1'b0);
    drain();

    base = n_acc;
    send(PT_B, K_B, CT_B, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      in_text  = rnd128();
      in_key   = rnd128();
      in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    drain();
    chk("ignored_accepts", 128'(n_acc), 128'(base + 1));

    rnd_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      t = rnd128();
      k = rnd128();
      send(t, k, ref_aes(t, k), 1'b0);
      drain();
    end
    rnd_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1);
  end

endmodule
